// File: rtl/sos_pkg.sv
// Shared types and constants for the biquad-cascade MAC sequencer.
package sos_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MAC   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [2:0] TAP_B0 = 3'd0;
   localparam logic [2:0] TAP_B1 = 3'd1;
   localparam logic [2:0] TAP_B2 = 3'd2;
   localparam logic [2:0] TAP_A1 = 3'd3;
   localparam logic [2:0] TAP_A2 = 3'd4;

   localparam int TAPS_PER_SECTION = 5;

endpackage

// File: rtl/sos_sequencer.sv
// Control sequencer for a cascade of second-order IIR sections sharing one MAC.
// Walks five taps per section, waits out the MAC pipeline, then commits the state update.
module sos_sequencer
   import sos_pkg::*;
#(
   parameter int SECTIONS    = 8,
   parameter int MAC_LATENCY = 2,
   parameter int SW          = $clog2(SECTIONS + 1)
) (
   input  logic          clk_i,
   input  logic          srst_i,
   input  logic          start_i,
   output logic          busy_o,
   output logic [SW-1:0] sec_addr_o,
   output logic [2:0]    tap_o,
   output logic          mac_clear_o,
   output logic          mac_en_o,
   output logic          in_sel_o,
   output logic          state_we_o,
   output logic          done_o,
   output logic          overrun_o
);

   localparam int DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
   localparam logic [SW-1:0] LAST_SEC   = SW'(SECTIONS - 1);
   localparam logic [DW-1:0] LAST_DRAIN = DW'(MAC_LATENCY - 1);

   state_e        r_state, w_state_nxt;
   logic [SW-1:0] r_sec, w_sec_nxt;
   logic [2:0]    r_tap, w_tap_nxt;
   logic [DW-1:0] r_drain, w_drain_nxt;

   logic r_busy, r_clear, r_en, r_in_sel, r_we, r_done, r_ovr;
   logic w_busy_nxt, w_clear_nxt, w_en_nxt, w_in_sel_nxt, w_we_nxt, w_done_nxt, w_ovr_nxt;

   // Next-state, counter and output decode; outputs are decoded from the next state so they register cleanly.
   always_comb begin
      w_state_nxt = r_state;
      w_sec_nxt   = r_sec;
      w_tap_nxt   = r_tap;
      w_drain_nxt = r_drain;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            w_sec_nxt   = '0;
            w_tap_nxt   = TAP_B0;
            w_drain_nxt = '0;
            if (start_i) begin
               w_state_nxt = ST_MAC;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MAC: begin
            if (r_tap == TAP_A2) begin
               w_state_nxt = ST_DRAIN;
               w_tap_nxt   = TAP_B0;
               w_drain_nxt = '0;
            end else begin
               w_tap_nxt   = r_tap + 3'd1;
            end
         end
         ST_DRAIN: begin
            if (r_drain == LAST_DRAIN) begin
               w_state_nxt = ST_WRITE;
            end else begin
               w_drain_nxt = r_drain + DW'(1);
            end
         end
         ST_WRITE: begin
            w_tap_nxt = TAP_B0;
            if (r_sec == LAST_SEC) begin
               w_state_nxt = ST_DONE;
               w_sec_nxt   = '0;
            end else begin
               w_state_nxt = ST_MAC;
               w_sec_nxt   = r_sec + SW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_sec_nxt   = '0;
            w_tap_nxt   = TAP_B0;
            w_drain_nxt = '0;
         end
      endcase

      w_busy_nxt   = (w_state_nxt == ST_MAC) || (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_WRITE);
      w_en_nxt     = (w_state_nxt == ST_MAC);
      w_clear_nxt  = (w_state_nxt == ST_MAC) && (w_tap_nxt == TAP_B0);
      w_we_nxt     = (w_state_nxt == ST_WRITE);
      w_done_nxt   = (w_state_nxt == ST_DONE);
      w_in_sel_nxt = w_busy_nxt && (w_sec_nxt != '0);
      // A start seen while a pass is running is dropped but remembered until reset.
      w_ovr_nxt    = r_ovr || (start_i && r_busy);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state  <= ST_IDLE;
         r_sec    <= '0;
         r_tap    <= TAP_B0;
         r_drain  <= '0;
         r_busy   <= 1'b0;
         r_clear  <= 1'b0;
         r_en     <= 1'b0;
         r_in_sel <= 1'b0;
         r_we     <= 1'b0;
         r_done   <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sec    <= w_sec_nxt;
         r_tap    <= w_tap_nxt;
         r_drain  <= w_drain_nxt;
         r_busy   <= w_busy_nxt;
         r_clear  <= w_clear_nxt;
         r_en     <= w_en_nxt;
         r_in_sel <= w_in_sel_nxt;
         r_we     <= w_we_nxt;
         r_done   <= w_done_nxt;
         r_ovr    <= w_ovr_nxt;
      end
   end

   assign busy_o      = r_busy;
   assign sec_addr_o  = r_sec;
   assign tap_o       = r_tap;
   assign mac_clear_o = r_clear;
   assign mac_en_o    = r_en;
   assign in_sel_o    = r_in_sel;
   assign state_we_o  = r_we;
   assign done_o      = r_done;
   assign overrun_o   = r_ovr;

endmodule
